// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared types for the ID-stage hazard scoreboard.
// Entry layout, forwarding-mode constants and control-mode encoding.
package hazard_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    // Entries hold dest zero-extended so one struct serves any address width
    localparam int SB_DEST_W = 8;

    localparam int FWD_NONE = 0;
    localparam int FWD_FULL = 1;

    typedef struct packed {
        logic                 v;
        logic [SB_DEST_W-1:0] dest;
        logic                 ld;
    } sb_entry_t;

    typedef enum logic [1:0] {
        CTL_RUN,
        CTL_STALL,
        CTL_SQUASH,
        CTL_FREEZE
    } ctl_mode_e;

    function automatic sb_entry_t sb_bubble();
        return '0;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// ID-stage bundle between the decode pipeline and the hazard scoreboard.
// master = pipeline side, slave = hazard controller.
interface hazard_scoreboard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_regwrite;
    logic                  id_memread;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  flush;
    logic                  mem_stall;
    logic                  cnt_clear;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  hazard_mux;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
        output id_regwrite, id_memread, id_dest,
        output flush, mem_stall, cnt_clear,
        input  pc_write, ifid_write, hazard_mux, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  id_regwrite, id_memread, id_dest,
        input  flush, mem_stall, cnt_clear,
        output pc_write, ifid_write, hazard_mux, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_ctrl_cmp.sv
// Compares the ID instruction's sources against one scoreboard entry.
// match = any RAW dependency; load_match = dependency on a load.
module hazard_sb_entry_cmp
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  sb_entry_t             entry,
    input  logic                  id_valid,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  match,
    output logic                  load_match
);

    logic rs_hit;
    logic rt_hit;
    logic live;

    assign rs_hit = id_uses_rs && (entry.dest == SB_DEST_W'(id_rs));
    assign rt_hit = id_uses_rt && (entry.dest == SB_DEST_W'(id_rt));

    // r0 is hard-wired zero, so a write to it is never a dependency
    assign live = entry.v && (entry.dest != '0) && id_valid;

    assign match      = live && (rs_hit || rt_hit);
    assign load_match = match && entry.ld;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// ID-stage hazard controller with an in-flight destination scoreboard.
// Drives PC / IF-ID freeze and bubble injection, counts stall cycles.
module hazard_scoreboard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W    = DEF_REG_ADDR_W,
    parameter int NUM_STAGES    = 2,
    parameter int FWD_MODE      = FWD_NONE,
    parameter int LOAD_USE_DIST = 1,
    parameter int CNT_W         = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    hazard_scoreboard_ctrl_if.slave hif
);

    if (NUM_STAGES < 1 || NUM_STAGES > 6) begin : g_bad_stages
        $error("NUM_STAGES must be 1..6");
    end
    if (LOAD_USE_DIST < 1 || LOAD_USE_DIST > NUM_STAGES) begin : g_bad_dist
        $error("LOAD_USE_DIST must be 1..NUM_STAGES");
    end
    if (REG_ADDR_W > SB_DEST_W) begin : g_bad_width
        $error("REG_ADDR_W exceeds scoreboard dest width");
    end

    sb_entry_t             sb_q [NUM_STAGES];
    sb_entry_t             sb_new;
    logic [NUM_STAGES-1:0] match;
    logic [NUM_STAGES-1:0] load_match;
    logic                  hazard;
    ctl_mode_e             mode;
    logic [CNT_W-1:0]      cnt_q;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_cmp
        hazard_sb_entry_cmp #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_cmp (
            .entry      (sb_q[k]),
            .id_valid   (hif.id_valid),
            .id_uses_rs (hif.id_uses_rs),
            .id_uses_rt (hif.id_uses_rt),
            .id_rs      (hif.id_rs),
            .id_rt      (hif.id_rt),
            .match      (match[k]),
            .load_match (load_match[k])
        );
    end

    // With forwarding only a load still too young to forward can stall
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (FWD_MODE == FWD_NONE) begin
                hazard = hazard | match[k];
            end else if (k < LOAD_USE_DIST) begin
                hazard = hazard | load_match[k];
            end
        end
    end

    always_comb begin
        mode = CTL_RUN;
        if (hif.mem_stall) begin
            mode = CTL_FREEZE;
        end else if (hif.flush) begin
            mode = CTL_SQUASH;
        end else if (hazard) begin
            mode = CTL_STALL;
        end
    end

    always_comb begin
        hif.pc_write   = 1'b1;
        hif.ifid_write = 1'b1;
        hif.hazard_mux = 1'b0;
        unique case (mode)
            CTL_FREEZE: begin
                hif.pc_write   = 1'b0;
                hif.ifid_write = 1'b0;
            end
            CTL_SQUASH: begin
                hif.hazard_mux = 1'b1;
            end
            CTL_STALL: begin
                hif.pc_write   = 1'b0;
                hif.ifid_write = 1'b0;
                hif.hazard_mux = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        sb_new      = sb_bubble();
        sb_new.v    = hif.id_valid && hif.id_regwrite && (mode == CTL_RUN);
        sb_new.dest = SB_DEST_W'(hif.id_dest);
        sb_new.ld   = hif.id_memread;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                sb_q[k] <= sb_bubble();
            end
        end else if (!hif.mem_stall) begin
            sb_q[0] <= sb_new;
            for (int k = 1; k < NUM_STAGES; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (hif.cnt_clear) begin
            cnt_q <= '0;
        end else if (mode == CTL_STALL && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hif.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Two configurations (no-forwarding / load-use only) driven in lockstep.
// Expected values come from a list-of-producers reference model.
module tb_hazard_scoreboard_ctrl;
    import hazard_pkg::*;

    localparam int CW0 = 4;
    localparam int CW1 = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_regwrite;
    logic       id_memread;
    logic [4:0] id_dest;
    logic       flush;
    logic       mem_stall;
    logic       cnt_clear;

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CW0)) hif0 ();
    hazard_scoreboard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CW1)) hif1 ();

    assign hif0.id_valid    = id_valid;
    assign hif0.id_rs       = id_rs;
    assign hif0.id_rt       = id_rt;
    assign hif0.id_uses_rs  = id_uses_rs;
    assign hif0.id_uses_rt  = id_uses_rt;
    assign hif0.id_regwrite = id_regwrite;
    assign hif0.id_memread  = id_memread;
    assign hif0.id_dest     = id_dest;
    assign hif0.flush       = flush;
    assign hif0.mem_stall   = mem_stall;
    assign hif0.cnt_clear   = cnt_clear;

    assign hif1.id_valid    = id_valid;
    assign hif1.id_rs       = id_rs;
    assign hif1.id_rt       = id_rt;
    assign hif1.id_uses_rs  = id_uses_rs;
    assign hif1.id_uses_rt  = id_uses_rt;
    assign hif1.id_regwrite = id_regwrite;
    assign hif1.id_memread  = id_memread;
    assign hif1.id_dest     = id_dest;
    assign hif1.flush       = flush;
    assign hif1.mem_stall   = mem_stall;
    assign hif1.cnt_clear   = cnt_clear;

    hazard_scoreboard_ctrl #(
        .REG_ADDR_W    (5),
        .NUM_STAGES    (2),
        .FWD_MODE      (FWD_NONE),
        .LOAD_USE_DIST (1),
        .CNT_W         (CW0)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif0)
    );

    hazard_scoreboard_ctrl #(
        .REG_ADDR_W    (5),
        .NUM_STAGES    (3),
        .FWD_MODE      (FWD_FULL),
        .LOAD_USE_DIST (1),
        .CNT_W         (CW1)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif1)
    );

    typedef struct {
        int dest;
        bit ld;
        int born;
    } prod_t;

    prod_t q [2][$];
    int    adv  [2];
    int    cnt  [2];
    int    seen [2];
    int    ns   [2] = '{2, 3};
    int    fwd  [2] = '{0, 1};
    int    lud  [2] = '{2, 1};
    int    cmax [2] = '{(1 << CW0) - 1, (1 << CW1) - 1};

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_haz(int d);
        int age;
        bit hit;
        if (!id_valid) return 1'b0;
        for (int i = 0; i < q[d].size(); i++) begin
            age = adv[d] - q[d][i].born;
            hit = (id_uses_rs && int'(id_rs) == q[d][i].dest) ||
                  (id_uses_rt && int'(id_rt) == q[d][i].dest);
            if (hit) begin
                if (fwd[d] == 0 && age < ns[d]) return 1'b1;
                if (fwd[d] == 1 && age < lud[d] && q[d][i].ld) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            q[d].delete();
            cnt[d] = 0;
        end
    endtask

    task automatic m_tick(int d, bit h);
        if (cnt_clear) cnt[d] = 0;
        else if (h && !flush && !mem_stall && cnt[d] < cmax[d]) cnt[d]++;
        if (!mem_stall) begin
            adv[d]++;
            if (id_valid && id_regwrite && !h && !flush && id_dest != 0)
                q[d].push_back('{int'(id_dest), id_memread, adv[d]});
            while (q[d].size() > 0 && adv[d] - q[d][0].born >= ns[d])
                void'(q[d].pop_front());
        end
    endtask

    task automatic step();
        bit       h [2];
        bit [2:0] exp_o;
        bit [2:0] got_o;
        int       got_c;
        if (!rst_n) m_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            h[d] = m_haz(d);
            if (mem_stall)  exp_o = 3'b000;
            else if (flush) exp_o = 3'b111;
            else if (h[d])  exp_o = 3'b001;
            else            exp_o = 3'b110;
            if (d == 0) begin
                got_o = {hif0.pc_write, hif0.ifid_write, hif0.hazard_mux};
                got_c = int'(hif0.stall_cnt);
            end else begin
                got_o = {hif1.pc_write, hif1.ifid_write, hif1.hazard_mux};
                got_c = int'(hif1.stall_cnt);
            end
            chk(d == 0 ? "u0.pc_write" : "u1.pc_write", got_o[2], exp_o[2]);
            chk(d == 0 ? "u0.ifid_write" : "u1.ifid_write", got_o[1], exp_o[1]);
            chk(d == 0 ? "u0.hazard_mux" : "u1.hazard_mux", got_o[0], exp_o[0]);
            chk(d == 0 ? "u0.stall_cnt" : "u1.stall_cnt", got_c, cnt[d]);
            if (got_o[0] && !got_o[2]) seen[d]++;
        end
        @(posedge clk);
        if (rst_n) begin
            m_tick(0, h[0]);
            m_tick(1, h[1]);
        end
        @(negedge clk);
    endtask

    task automatic drive(bit v, int rs, int rt, bit urs, bit urt,
                         bit rw, bit mr, int dst);
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_regwrite = rw;
        id_memread  = mr;
        id_dest     = 5'(dst);
    endtask

    // mode 0 plain, 1 mem_stall mid-stall, 2 flush on first consumer cycle
    task automatic pair(string tag, bit load, int pd, int crs, int crt,
                        bit urs, bit urt, int e0, int e1, int mode);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        drive(1, 1, 2, 1, 1, 1, load, pd);
        step();
        seen[0] = 0;
        seen[1] = 0;
        drive(1, crs, crt, urs, urt, 1, 0, 7);
        for (int i = 0; i < 6; i++) begin
            mem_stall = (mode == 1 && i >= 1 && i <= 3);
            flush     = (mode == 2 && i == 0);
            step();
        end
        mem_stall = 1'b0;
        flush     = 1'b0;
        chk({tag, "_stalls_u0"}, seen[0], e0);
        chk({tag, "_stalls_u1"}, seen[1], e1);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        mem_stall = 1'b0;
        cnt_clear = 1'b0;
        adv       = '{0, 0};
        seen      = '{0, 0};
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        pair("alu_rs",   0, 3, 3, 9, 1, 1, 2, 0, 0);
        pair("load_rt",  1, 5, 9, 5, 1, 1, 2, 1, 0);
        pair("r0_dest",  1, 0, 0, 0, 1, 1, 0, 0, 0);
        pair("rt_unused", 1, 5, 6, 5, 1, 0, 0, 0, 0);
        pair("memstall", 1, 3, 3, 9, 1, 1, 2, 1, 1);
        pair("flush",    0, 3, 3, 9, 1, 1, 1, 0, 2);

        repeat (10) pair("sat", 1, 4, 4, 4, 1, 1, 2, 1, 0);
        #1;
        chk("u0.saturated", hif0.stall_cnt, (1 << CW0) - 1);
        @(negedge clk);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        #1;
        chk("u0.cleared", hif0.stall_cnt, 0);
        chk("u1.cleared", hif1.stall_cnt, 0);
        @(negedge clk);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        drive(1, 1, 2, 1, 1, 1, 1, 3);
        step();
        drive(1, 3, 3, 1, 1, 1, 0, 7);
        step();
        rst_n = 1'b0;
        step();
        #1;
        chk("rst.pc_write", hif0.pc_write, 1);
        chk("rst.hazard_mux", hif0.hazard_mux, 0);
        chk("rst.stall_cnt", hif0.stall_cnt, 0);
        rst_n = 1'b1;
        seen[0] = 0;
        seen[1] = 0;
        step();
        step();
        chk("rst_stalls_u0", seen[0], 0);
        chk("rst_stalls_u1", seen[1], 0);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 7));
            mem_stall = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            cnt_clear = ($urandom_range(0, 49) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        flush     = 1'b0;
        cnt_clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
